// File: rtl/if_fetch_stage_if.sv
// Fetch stage bus: instruction memory port, decode handshake
// and execute redirect, grouped for the if_fetch_stage ports.
interface if_fetch_stage_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_redirect_en;
  logic [31:0] i_redirect_pc;
  logic        o_misalign;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_rdata,
    output o_valid,
    input  i_ready,
    output o_instr,
    output o_pc,
    input  i_redirect_en,
    input  i_redirect_pc,
    output o_misalign
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_rdata,
    input  o_valid,
    output i_ready,
    input  o_instr,
    input  o_pc,
    output i_redirect_en,
    output i_redirect_pc,
    input  o_misalign
  );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32I fetch stage: PC, synchronous imem reads, 2-entry
// instruction queue to decode, redirect with stale-fetch discard.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic              i_clk,
  input logic              i_rst_n,
  if_fetch_stage_if.master bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      q0_q, q0_d;
  entry_t      q1_q, q1_d;
  entry_t      new_e;
  logic [1:0]  cnt_q, cnt_d;
  logic        infl_q, infl_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        mis_q, mis_d;

  logic        pop;
  logic        push;
  logic        issue;
  logic        redir;
  logic [1:0]  occ;

  always_comb begin
    redir = bus.i_redirect_en;
    pop   = (cnt_q != 2'd0) & bus.i_ready;
    occ   = cnt_q + {1'b0, infl_q};
    // Refill only when a slot is free now or freed by this pop
    issue = i_rst_n & ~redir &
            ((occ < 2'd2) | ((occ == 2'd2) & pop));
    // Data for a read issued before a redirect is stale
    push  = infl_q & ~redir;
    new_e = '{pc: infl_pc_q, instr: bus.i_imem_rdata};

    q0_d       = q0_q;
    q1_d       = q1_q;
    cnt_d      = cnt_q;
    infl_d     = issue;
    infl_pc_d  = infl_pc_q;
    fetch_pc_d = fetch_pc_q;
    mis_d      = redir & (bus.i_redirect_pc[1:0] != 2'b00);

    if (issue) begin
      infl_pc_d  = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redir) begin
      fetch_pc_d = {bus.i_redirect_pc[31:2], 2'b00};
      cnt_d      = 2'd0;
    end else begin
      unique case ({pop, push})
        2'b11: begin
          if (cnt_q == 2'd1) begin
            q0_d = new_e;
          end else begin
            q0_d = q1_q;
            q1_d = new_e;
          end
        end
        2'b10: begin
          q0_d  = q1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd0) q0_d = new_e;
          else               q1_d = new_e;
          cnt_d = cnt_q + 2'd1;
        end
        2'b00: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_pc_q <= RESET_PC;
      cnt_q      <= 2'd0;
      infl_q     <= 1'b0;
      infl_pc_q  <= 32'd0;
      q0_q       <= '0;
      q1_q       <= '0;
      mis_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
      infl_q     <= infl_d;
      infl_pc_q  <= infl_pc_d;
      q0_q       <= q0_d;
      q1_q       <= q1_d;
      mis_q      <= mis_d;
    end
  end

  assign bus.o_imem_req  = issue;
  assign bus.o_imem_addr = fetch_pc_q;
  assign bus.o_valid     = cnt_q != 2'd0;
  assign bus.o_instr     = bus.o_valid ? q0_q.instr : NOP_INSTR;
  assign bus.o_pc        = bus.o_valid ? q0_q.pc : 32'd0;
  assign bus.o_misalign  = mis_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: scoreboard of presented PCs,
// redirect table, stall, back-to-back redirect and PC wrap.
module tb_if_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n;
  logic rst2_n;

  if_fetch_stage_if b1();
  if_fetch_stage_if b2();

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut1 (
    .i_clk  (clk),
    .i_rst_n(rst1_n),
    .bus    (b1.master)
  );

  if_fetch_stage #(
    .RESET_PC (32'hFFFF_FFF8),
    .NOP_INSTR(32'h0000_0013)
  ) dut2 (
    .i_clk  (clk),
    .i_rst_n(rst2_n),
    .bus    (b2.master)
  );

  // memory word at address a holds a + 0x100
  always @(posedge clk) begin
    b1.i_imem_rdata <= b1.o_imem_req ?
      b1.o_imem_addr + 32'h100 : 32'hDEAD_BEEF;
    b2.i_imem_rdata <= b2.o_imem_req ?
      b2.o_imem_addr + 32'h100 : 32'hDEAD_BEEF;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [31:0] sb[$];
  logic        sb_on = 1'b0;

  task automatic sb_load(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 64; i++) sb.push_back(start + 32'(4 * i));
  endtask

  always @(negedge clk) begin
    if (sb_on && rst1_n && b1.o_valid && b1.i_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_empty: got pc %h expected none", b1.o_pc);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("sb_pc", b1.o_pc, e);
        chk("sb_instr", b1.o_instr, e + 32'h100);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] rpc;
    logic        mis;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h0000_0202, 1'b1, 32'h0000_0200};
    tbl[1] = '{32'h0000_0301, 1'b1, 32'h0000_0300};
    tbl[2] = '{32'h0000_0403, 1'b1, 32'h0000_0400};
    tbl[3] = '{32'h0000_0500, 1'b0, 32'h0000_0500};
    tbl[4] = '{32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFC};

    rst1_n           = 1'b0;
    rst2_n           = 1'b0;
    b1.i_ready       = 1'b0;
    b1.i_redirect_en = 1'b1;
    b1.i_redirect_pc = 32'h0000_0803;
    b2.i_ready       = 1'b1;
    b2.i_redirect_en = 1'b0;
    b2.i_redirect_pc = 32'h0;

    // reset, with a redirect that must be ignored
    repeat (3) begin tick(); smp(); end
    chk("rst_valid", {31'b0, b1.o_valid}, 32'd0);
    chk("rst_instr", b1.o_instr, 32'h0000_0013);
    chk("rst_pc", b1.o_pc, 32'd0);
    chk("rst_mis", {31'b0, b1.o_misalign}, 32'd0);
    chk("rst_req", {31'b0, b1.o_imem_req}, 32'd0);

    // C0
    tick();
    rst1_n = 1'b1;
    b1.i_redirect_en = 1'b0;
    b1.i_ready = 1'b1;
    sb_load(32'h0);
    sb_on = 1'b1;
    smp();
    chk("c0_req", {31'b0, b1.o_imem_req}, 32'd1);
    chk("c0_addr", b1.o_imem_addr, 32'h0);
    chk("c0_mis", {31'b0, b1.o_misalign}, 32'd0);
    tick(); smp();
    chk("c1_valid", {31'b0, b1.o_valid}, 32'd0);
    tick(); smp();
    chk("c2_valid", {31'b0, b1.o_valid}, 32'd1);
    chk("c2_pc", b1.o_pc, 32'h0);
    chk("c2_instr", b1.o_instr, 32'h100);
    for (int i = 0; i < 6; i++) begin
      tick(); smp();
      chk("stream_valid", {31'b0, b1.o_valid}, 32'd1);
    end

    // fresh reset, then stall at first valid
    tick();
    rst1_n = 1'b0;
    sb_on = 1'b0;
    smp();
    tick();
    rst1_n = 1'b1;
    sb_load(32'h0);
    sb_on = 1'b1;
    smp();
    tick(); smp();
    chk("stl_c1_valid", {31'b0, b1.o_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      b1.i_ready = 1'b0;
      smp();
      chk("stl_valid", {31'b0, b1.o_valid}, 32'd1);
      chk("stl_pc", b1.o_pc, 32'h0);
      chk("stl_req", {31'b0, b1.o_imem_req}, 32'd0);
    end
    tick();
    b1.i_ready = 1'b1;
    smp();
    chk("rel_req", {31'b0, b1.o_imem_req}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(); smp();
      chk("rel_valid", {31'b0, b1.o_valid}, 32'd1);
    end

    // fill both entries, then redirect to 0x200
    for (int i = 0; i < 3; i++) begin
      tick();
      b1.i_ready = 1'b0;
      smp();
    end
    chk("full_valid", {31'b0, b1.o_valid}, 32'd1);
    chk("full_req", {31'b0, b1.o_imem_req}, 32'd0);
    tick();
    b1.i_redirect_en = 1'b1;
    b1.i_redirect_pc = 32'h200;
    sb_load(32'h200);
    smp();
    chk("rd_req", {31'b0, b1.o_imem_req}, 32'd0);
    tick();
    b1.i_redirect_en = 1'b0;
    b1.i_ready = 1'b1;
    smp();
    chk("rd1_valid", {31'b0, b1.o_valid}, 32'd0);
    chk("rd1_req", {31'b0, b1.o_imem_req}, 32'd1);
    chk("rd1_addr", b1.o_imem_addr, 32'h200);
    chk("rd1_mis", {31'b0, b1.o_misalign}, 32'd0);
    tick(); smp();
    chk("rd2_valid", {31'b0, b1.o_valid}, 32'd0);
    tick(); smp();
    chk("rd3_valid", {31'b0, b1.o_valid}, 32'd1);
    chk("rd3_pc", b1.o_pc, 32'h200);
    repeat (2) begin tick(); smp(); end

    // redirect table: misalign pulse and aligned target
    foreach (tbl[k]) begin
      tick();
      b1.i_ready = 1'b0;
      b1.i_redirect_en = 1'b1;
      b1.i_redirect_pc = tbl[k].rpc;
      sb_load(tbl[k].addr);
      smp();
      chk("tv_req0", {31'b0, b1.o_imem_req}, 32'd0);
      tick();
      b1.i_redirect_en = 1'b0;
      b1.i_ready = 1'b1;
      smp();
      chk("tv_mis", {31'b0, b1.o_misalign}, {31'b0, tbl[k].mis});
      chk("tv_req", {31'b0, b1.o_imem_req}, 32'd1);
      chk("tv_addr", b1.o_imem_addr, tbl[k].addr);
      chk("tv_valid0", {31'b0, b1.o_valid}, 32'd0);
      tick(); smp();
      chk("tv_mis_end", {31'b0, b1.o_misalign}, 32'd0);
      tick(); smp();
      chk("tv_valid", {31'b0, b1.o_valid}, 32'd1);
      repeat (2) begin tick(); smp(); end
    end

    // back-to-back redirects: last wins
    tick();
    b1.i_ready = 1'b0;
    b1.i_redirect_en = 1'b1;
    b1.i_redirect_pc = 32'h300;
    smp();
    chk("bb1_req", {31'b0, b1.o_imem_req}, 32'd0);
    tick();
    b1.i_redirect_pc = 32'h400;
    sb_load(32'h400);
    smp();
    chk("bb2_req", {31'b0, b1.o_imem_req}, 32'd0);
    tick();
    b1.i_redirect_en = 1'b0;
    b1.i_ready = 1'b1;
    smp();
    chk("bb_addr", b1.o_imem_addr, 32'h400);
    tick(); smp();
    chk("bb_valid0", {31'b0, b1.o_valid}, 32'd0);
    tick(); smp();
    chk("bb_valid", {31'b0, b1.o_valid}, 32'd1);
    chk("bb_pc", b1.o_pc, 32'h400);
    repeat (3) begin tick(); smp(); end

    // PC wrap past 2^32, then reset mid-stream
    tick();
    rst2_n = 1'b1;
    smp();
    chk("w_c0_req", {31'b0, b2.o_imem_req}, 32'd1);
    chk("w_c0_addr", b2.o_imem_addr, 32'hFFFF_FFF8);
    tick(); smp();
    tick(); smp();
    chk("w_pc0", b2.o_pc, 32'hFFFF_FFF8);
    chk("w_in0", b2.o_instr, 32'h0000_00F8);
    tick(); smp();
    chk("w_pc1", b2.o_pc, 32'hFFFF_FFFC);
    chk("w_in1", b2.o_instr, 32'h0000_00FC);
    tick(); smp();
    chk("w_pc2", b2.o_pc, 32'h0000_0000);
    chk("w_in2", b2.o_instr, 32'h0000_0100);
    tick();
    rst2_n = 1'b0;
    smp();
    tick(); smp();
    chk("w_rst_valid", {31'b0, b2.o_valid}, 32'd0);
    chk("w_rst_instr", b2.o_instr, 32'h0000_0013);
    chk("w_rst_req", {31'b0, b2.o_imem_req}, 32'd0);
    tick();
    rst2_n = 1'b1;
    smp();
    tick(); smp();
    chk("w_r1_valid", {31'b0, b2.o_valid}, 32'd0);
    tick(); smp();
    chk("w_r2_pc", b2.o_pc, 32'hFFFF_FFF8);
    chk("w_r2_valid", {31'b0, b2.o_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
